dp_lane_mapper: RTL and testbench
=================================

// Module: dp_lane_mapper
// PURPOSE
//  Upstream stage of the DP main-link encoder. Buffers the pixel stream and maps it onto 4 lanes as
//  8-bit symbols plus a K-flag per lane. Stripes 4-pixel groups across the lanes and frames each
//  active line with BE (K27.7) and BS (K28.5) + VB-ID. Output feeds the per-lane 8b/10b encoders.
// PARAMETERS
//  FIFO_DEPTH  8      pixel FIFO entries; power of 2, >=4
//  IDLE_SYM    8'h00  data symbol sent on every lane during blanking
// PORTS
//  pixel_clk      in   1   clock
//  rst_n          in   1   reset, asynchronous, active-low
//  in_valid       in   1   input pixel valid
//  in_ready       out  1   = FIFO not full (combinational from level)
//  in_r/in_g/in_b in   12  pixel components; only [11:4] used
//  in_de          in   1   active-video flag
//  in_vsync       in   1   vertical sync; sampled on blanking pixels
//  out_valid      out  1   symbol word valid
//  out_ready      in   1   downstream accepts the word
//  out_sym        out  32  lane i symbol = out_sym[8i+7:8i]
//  out_k          out  4   per-lane K-symbol flag
//  fifo_level     out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
//  ovf_sticky     out  1   set when in_valid && !in_ready; cleared only by reset
// BEHAVIOUR
//  Reset (async): FSM=S_BLANK; FIFO empty; grp_cnt=0; phase=0; vblank_flag=1.
//   Outputs at reset: out_valid=1, out_sym={4{IDLE_SYM}}, out_k=0, in_ready=1, fifo_level=0, ovf_sticky=0.
//   Reset mid-line discards all buffered pixels. No BS is emitted for the aborted line.
//  FIFO: entry = {de, vsync, r[11:4], g[11:4], b[11:4]} (26b). Push on in_valid && in_ready.
//   A pushed entry is visible at the head on the next cycle.
//   Simultaneous push+pop keeps the level unchanged. Pointers wrap modulo FIFO_DEPTH.
//  Word accepted = out_valid && out_ready. All outputs are combinational from FSM state and registers.
//  FSM:
//   S_BLANK : out_valid=1, sym={4{IDLE_SYM}}, k=0.
//             Head de=0: pop it and set vblank_flag<=head.vsync. The pop does not wait on out_ready.
//             Head de=1: no pop; next state S_BE. Empty: stay.
//   S_BE    : out_valid=1, sym={4{8'hFB}}, k=4'hF. On accept -> S_GATHER.
//   S_GATHER: out_valid=0.
//             Head de=1: pop into grp[grp_cnt] and grp_cnt++. When grp_cnt reaches 4 -> S_EMIT.
//             Head de=0 (do not pop), grp_cnt>0: zero-pad grp[grp_cnt..3], set last=1, -> S_EMIT.
//             Head de=0 (do not pop), grp_cnt==0: -> S_BS.
//             Empty: wait (underrun). Stays in S_GATHER with no timeout.
//   S_EMIT  : out_valid=1, k=0. Lane i carries component[phase] of grp[i].
//             phase 0=R, 1=G, 2=B. Phase advances on accept.
//             After the phase-2 accept: grp_cnt=0; go to S_BS if last, else S_GATHER.
//             last is cleared on leaving S_EMIT.
//   S_BS    : out_valid=1, sym={4{8'hBC}}, k=4'hF. On accept -> S_VBID.
//   S_VBID  : out_valid=1, sym={4{7'b0,vblank_flag}}, k=0. On accept -> S_BLANK.
//  out_valid=1 with out_ready=0: out_sym/out_k held stable, no state advance.
//   FIFO pops in S_BLANK continue; the BLANK word content does not change.
//  Throughput: 3 output words per 4 active pixels.
//   A new pixel every cycle with out_ready=1 cannot be sustained: the 4-cycle GATHER plus
//   3-cycle EMIT fills the FIFO. Backpressure via in_ready; ovf_sticky flags a source that ignores it.
//  Latency: head de=1 in S_BLANK -> BE presented in the same cycle the FSM enters S_BE (next clock).
// CONFIGURATION
//  DP_MAPPER_STATS_EN defined:
//   - Adds output line_pix_cnt [15:0]: the count of de=1 pixels popped in the last completed line.
//   - Updated in the cycle S_BS is entered; holds until the next line ends. Reset value 0.
//   - The count saturates at 16'hFFFF.
//  Undefined: port and counter are absent; all other behaviour is identical.
// TESTING
//  - Reset release, in_valid=0, out_ready=1 -> out_valid=1, sym=32'h0, k=0 every cycle;
//    fifo_level=0; ovf_sticky=0.
//  - Line of 4 pixels R/G/B=0x1n0/0x2n0/0x3n0 (n=0..3) framed by de=0 -> words
//    FBFBFBFB(k=F), 13121110, 23222120, 33323130, BCBCBCBC(k=F), 00000000 (VB-ID, vsync=0).
//  - 6-pixel line -> 2 groups. Second group lanes 2,3 = 0x00 in all 3 words, then BS.
//    line_pix_cnt=6 when STATS_EN is defined.
//  - Blanking pixel with vsync=1 before a line -> VB-ID word = 32'h01010101; vsync=0 -> 32'h00000000.
//  - out_ready=0 for 10 cycles during S_EMIT phase 1 -> G word held unchanged.
//    FIFO fills to 8, in_ready=0; in_valid=1 on a full cycle -> ovf_sticky=1 and stays 1.
//  - rst_n low for 1 cycle mid S_EMIT -> next cycle: S_BLANK, fifo_level=0, out_sym=0, k=0, vblank_flag=1.

Source files
------------

// File: rtl/dp_lane_mapper_if.sv
// Pixel-in / symbol-out bus of the DP lane mapper.
// Ports: source side in_valid/in_ready/in_r/in_g/in_b/in_de/in_vsync,
//        lane side out_valid/out_ready/out_sym[31:0]/out_k[3:0].
// master = testbench/source+sink view, slave = mapper view.
interface dp_lane_mapper_if;
  logic        in_valid;
  logic        in_ready;
  logic [11:0] in_r;
  logic [11:0] in_g;
  logic [11:0] in_b;
  logic        in_de;
  logic        in_vsync;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sym;
  logic [3:0]  out_k;

  modport master (
    output in_valid, in_r, in_g, in_b, in_de, in_vsync, out_ready,
    input  in_ready, out_valid, out_sym, out_k
  );

  modport slave (
    input  in_valid, in_r, in_g, in_b, in_de, in_vsync, out_ready,
    output in_ready, out_valid, out_sym, out_k
  );
endinterface

// File: rtl/dp_lane_mapper.sv
// DP main-link lane mapper: buffers pixels and stripes 4-pixel groups over 4 lanes
// as 8-bit symbols + K flags, framing each active line with BE and BS + VB-ID.
// Ports: pixel_clk, rst_n (async, active-low), bus (dp_lane_mapper_if.slave),
//        fifo_level (FIFO occupancy), ovf_sticky (push attempted while full).
// Optional: DP_MAPPER_STATS_EN adds line_pix_cnt[15:0] (de=1 pixels of last line).

// Purpose: small synchronous FIFO holding one pixel entry per slot.
// Latency: a pushed entry is at the head on the next cycle.
// Backpressure: caller must gate push with !full and pop with !empty.
module dp_lane_mapper_fifo #(
  parameter int W = 26,
  parameter int D = 8
) (
  input  logic               pixel_clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic [W-1:0]       push_dat,
  input  logic               pop,
  output logic [W-1:0]       head_dat,
  output logic [$clog2(D):0] level
);
  localparam int AW = $clog2(D);
  localparam int LW = AW + 1;

  logic [W-1:0]  mem [D];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;

  always_ff @(posedge pixel_clk) begin
    if (push) mem[wr_ptr] <= push_dat;
  end

  // Pointers wrap naturally since D is a power of two.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  assign head_dat = mem[rd_ptr];
endmodule

// Purpose: map buffered pixels onto 4 DP lanes with BE/BS/VB-ID line framing.
// Latency: head pixel with de=1 in blanking -> BE word on the next clock.
// Backpressure: out_ready=0 holds the word and state; in_ready drops when FIFO is full.
module dp_lane_mapper #(
  parameter int         FIFO_DEPTH = 8,
  parameter logic [7:0] IDLE_SYM   = 8'h00
) (
  input  logic                          pixel_clk,
  input  logic                          rst_n,
  dp_lane_mapper_if.slave               bus,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          ovf_sticky
`ifdef DP_MAPPER_STATS_EN
  ,
  output logic [15:0]                   line_pix_cnt
`endif
);
  localparam int LW = $clog2(FIFO_DEPTH) + 1;

  typedef enum logic [2:0] {
    S_BLANK,
    S_BE,
    S_GATHER,
    S_EMIT,
    S_BS,
    S_VBID
  } state_t;

  state_t      state;
  state_t      nxt;
  logic [23:0] grp [4];
  logic [2:0]  grp_cnt;
  logic [1:0]  phase;
  logic        last;
  logic        vblank_flag;

  logic        push;
  logic        pop;
  logic [25:0] head;
  logic        empty;
  logic        vld_w;
  logic [31:0] sym_w;
  logic [3:0]  k_w;
  logic        accept;

  // Only the top 8 bits of each component travel down the link.
  logic [11:0] unused_lsbs;
  assign unused_lsbs = {bus.in_r[3:0], bus.in_g[3:0], bus.in_b[3:0]};

  assign bus.in_ready = (fifo_level != LW'(FIFO_DEPTH));
  assign push         = bus.in_valid && bus.in_ready;
  assign empty        = (fifo_level == '0);

  dp_lane_mapper_fifo #(
    .W (26),
    .D (FIFO_DEPTH)
  ) u_fifo (
    .pixel_clk (pixel_clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_dat  ({bus.in_de, bus.in_vsync, bus.in_r[11:4], bus.in_g[11:4], bus.in_b[11:4]}),
    .pop       (pop),
    .head_dat  (head),
    .level     (fifo_level)
  );

  always_comb begin
    nxt   = state;
    pop   = 1'b0;
    vld_w = 1'b0;
    sym_w = {4{IDLE_SYM}};
    k_w   = 4'h0;
    case (state)
      S_BLANK: begin
        vld_w = 1'b1;
        // Blanking pixels drain without waiting for the sink.
        if (!empty) begin
          if (head[25]) nxt = S_BE;
          else          pop = 1'b1;
        end
      end
      S_BE: begin
        vld_w = 1'b1;
        sym_w = {4{8'hFB}};
        k_w   = 4'hF;
        if (bus.out_ready) nxt = S_GATHER;
      end
      S_GATHER: begin
        if (!empty) begin
          if (head[25]) begin
            pop = 1'b1;
            if (grp_cnt == 3'd3) nxt = S_EMIT;
          end else if (grp_cnt != 3'd0) begin
            nxt = S_EMIT;
          end else begin
            nxt = S_BS;
          end
        end
      end
      S_EMIT: begin
        vld_w = 1'b1;
        for (int i = 0; i < 4; i++) begin
          case (phase)
            2'd0:    sym_w[8*i +: 8] = grp[i][23:16];
            2'd1:    sym_w[8*i +: 8] = grp[i][15:8];
            default: sym_w[8*i +: 8] = grp[i][7:0];
          endcase
        end
        if (bus.out_ready && phase == 2'd2) nxt = last ? S_BS : S_GATHER;
      end
      S_BS: begin
        vld_w = 1'b1;
        sym_w = {4{8'hBC}};
        k_w   = 4'hF;
        if (bus.out_ready) nxt = S_VBID;
      end
      S_VBID: begin
        vld_w = 1'b1;
        sym_w = {4{7'b0, vblank_flag}};
        if (bus.out_ready) nxt = S_BLANK;
      end
      default: nxt = S_BLANK;
    endcase
  end

  assign accept        = vld_w && bus.out_ready;
  assign bus.out_valid = vld_w;
  assign bus.out_sym   = sym_w;
  assign bus.out_k     = k_w;

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_BLANK;
      grp_cnt     <= '0;
      phase       <= '0;
      last        <= 1'b0;
      vblank_flag <= 1'b1;
      for (int i = 0; i < 4; i++) grp[i] <= '0;
    end else begin
      state <= nxt;
      if (state == S_BLANK && pop) vblank_flag <= head[24];
      if (state == S_GATHER && pop) begin
        grp[grp_cnt[1:0]] <= head[23:0];
        grp_cnt           <= grp_cnt + 3'd1;
      end
      // Short final group: blank out the lanes that never got a pixel.
      if (state == S_GATHER && nxt == S_EMIT && !pop) begin
        last <= 1'b1;
        for (int i = 0; i < 4; i++) begin
          if (3'(i) >= grp_cnt) grp[i] <= '0;
        end
      end
      if (state == S_EMIT && accept) begin
        if (phase == 2'd2) begin
          phase   <= '0;
          grp_cnt <= '0;
          last    <= 1'b0;
        end else begin
          phase <= phase + 2'd1;
        end
      end
    end
  end

  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n)                              ovf_sticky <= 1'b0;
    else if (bus.in_valid && !bus.in_ready)  ovf_sticky <= 1'b1;
  end

`ifdef DP_MAPPER_STATS_EN
  logic [15:0] run_cnt;

  // Entering S_BS never coincides with a pop, so run_cnt is final here.
  always_ff @(posedge pixel_clk or negedge rst_n) begin
    if (!rst_n) begin
      run_cnt      <= '0;
      line_pix_cnt <= '0;
    end else if (nxt == S_BS && state != S_BS) begin
      line_pix_cnt <= run_cnt;
      run_cnt      <= '0;
    end else if (state == S_GATHER && pop && run_cnt != 16'hFFFF) begin
      run_cnt <= run_cnt + 16'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dp_lane_mapper.sv
module tb_dp_lane_mapper;
  logic        pixel_clk = 1'b0;
  logic        rst_n     = 1'b0;
  logic [3:0]  fifo_level;
  logic        ovf_sticky;
`ifdef DP_MAPPER_STATS_EN
  logic [15:0] line_pix_cnt;
`endif

  int total = 0;
  int bad   = 0;
  bit rnd_rdy = 1'b0;

  logic [35:0] got   [$];
  logic [25:0] pq    [$];
  logic [35:0] exp_q [$];

  localparam logic [35:0] W_BE = {4'hF, 32'hFBFBFBFB};
  localparam logic [35:0] W_BS = {4'hF, 32'hBCBCBCBC};

  always #5 pixel_clk = ~pixel_clk;

  dp_lane_mapper_if bus ();

  dp_lane_mapper #(
    .FIFO_DEPTH (8),
    .IDLE_SYM   (8'h00)
  ) dut (
    .pixel_clk  (pixel_clk),
    .rst_n      (rst_n),
    .bus        (bus.slave),
    .fifo_level (fifo_level),
    .ovf_sticky (ovf_sticky)
`ifdef DP_MAPPER_STATS_EN
    ,
    .line_pix_cnt (line_pix_cnt)
`endif
  );

  // Inputs change only at posedge+1, so what is seen here is what the next edge commits.
  always @(negedge pixel_clk) begin
    if (rst_n) begin
      if (bus.out_valid && bus.out_ready) got.push_back({bus.out_k, bus.out_sym});
      if (bus.in_valid && bus.in_ready)
        pq.push_back({bus.in_de, bus.in_vsync, bus.in_r[11:4], bus.in_g[11:4], bus.in_b[11:4]});
    end
  end

  task automatic chk(input string tag, input logic [35:0] obs, input logic [35:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge pixel_clk);
    #1;
    if (rnd_rdy) bus.out_ready = ($urandom_range(0, 3) != 0);
  endtask

  task automatic drain(input int n);
    repeat (n) step();
  endtask

  task automatic send(input logic de, input logic vs, input logic [7:0] r, input logic [7:0] g,
                      input logic [7:0] b);
    bit ok = 1'b0;
    int t  = 0;
    bus.in_valid = 1'b1;
    bus.in_de    = de;
    bus.in_vsync = vs;
    bus.in_r     = {r, 4'($urandom)};
    bus.in_g     = {g, 4'($urandom)};
    bus.in_b     = {b, 4'($urandom)};
    while (!ok && t < 500) begin
      @(negedge pixel_clk);
      ok = bus.in_ready;
      step();
      t++;
    end
    bus.in_valid = 1'b0;
    chk("send_accepted", 36'(ok), 36'd1);
  endtask

  task automatic wait_word(input string tag, input logic [31:0] w);
    int t = 0;
    @(negedge pixel_clk);
    while (!(bus.out_valid && bus.out_k == 4'h0 && bus.out_sym == w) && t < 100) begin
      @(negedge pixel_clk);
      t++;
    end
    chk(tag, 36'(t < 100), 36'd1);
  endtask

  // Reference: walk the accepted pixel list line by line and list the words it must produce.
  task automatic build_model();
    bit vb = 1'b1;
    int i  = 0;
    exp_q.delete();
    while (i < pq.size()) begin
      if (!pq[i][25]) begin
        vb = pq[i][24];
        i++;
      end else begin
        int j = i;
        int n;
        while (j < pq.size() && pq[j][25]) j++;
        if (j >= pq.size()) break;
        n = j - i;
        exp_q.push_back(W_BE);
        for (int g = 0; g < n; g += 4) begin
          for (int ph = 0; ph < 3; ph++) begin
            logic [31:0] w;
            w = '0;
            for (int l = 0; l < 4; l++)
              if (g + l < n) w[8*l +: 8] = pq[i+g+l][23 - 8*ph -: 8];
            exp_q.push_back({4'h0, w});
          end
        end
        exp_q.push_back(W_BS);
        exp_q.push_back({4'h0, vb ? 32'h01010101 : 32'h00000000});
        i = j;
      end
    end
  endtask

  // Idle words may appear anywhere a line could start; everything else must match in order.
  task automatic check_stream(input string tag);
    int gi    = 0;
    int extra = 0;
    foreach (exp_q[e]) begin
      if (exp_q[e] == W_BE)
        while (gi < got.size() && got[gi] == 36'h0) gi++;
      if (gi < got.size()) begin
        chk(tag, got[gi], exp_q[e]);
        gi++;
      end else begin
        chk({tag, "_short"}, 36'(got.size()), 36'(gi + 1));
        break;
      end
    end
    for (int k = gi; k < got.size(); k++) if (got[k] != 36'h0) extra++;
    chk({tag, "_tail"}, 36'(extra), 36'd0);
  endtask

  initial begin
    bus.in_valid  = 1'b0;
    bus.in_de     = 1'b0;
    bus.in_vsync  = 1'b0;
    bus.in_r      = '0;
    bus.in_g      = '0;
    bus.in_b      = '0;
    bus.out_ready = 1'b1;

    // Reset and idle blanking
    repeat (3) @(posedge pixel_clk);
    #1 rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge pixel_clk);
      chk("rst_valid", 36'(bus.out_valid), 36'd1);
      chk("rst_word", {bus.out_k, bus.out_sym}, 36'h0);
      chk("rst_level", 36'(fifo_level), 36'd0);
      chk("rst_ovf", 36'(ovf_sticky), 36'd0);
      chk("rst_in_ready", 36'(bus.in_ready), 36'd1);
    end
    step();

    // 4-pixel line
    got.delete();
    send(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int n = 0; n < 4; n++) send(1'b1, 1'b0, 8'h10 + 8'(n), 8'h20 + 8'(n), 8'h30 + 8'(n));
    send(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    drain(30);
    exp_q = {W_BE, 36'h0_13121110, 36'h0_23222120, 36'h0_33323130, W_BS, 36'h0_00000000};
    check_stream("line4");

    // 6-pixel line after a vsync blanking pixel
    got.delete();
    send(1'b0, 1'b1, 8'h00, 8'h00, 8'h00);
    for (int n = 0; n < 6; n++) send(1'b1, 1'b0, 8'h40 + 8'(n), 8'h50 + 8'(n), 8'h60 + 8'(n));
    send(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    drain(30);
    exp_q = {W_BE, 36'h0_43424140, 36'h0_53525150, 36'h0_63626160,
             36'h0_00004544, 36'h0_00005554, 36'h0_00006564, W_BS, 36'h0_01010101};
    check_stream("line6");
`ifdef DP_MAPPER_STATS_EN
    chk("line_pix_cnt", 36'(line_pix_cnt), 36'd6);
`endif

    // Sink stall in the G word while the source fills the FIFO and then overruns it
    got.delete();
    pq.delete();
    send(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int n = 0; n < 4; n++) send(1'b1, 1'b0, 8'h70 + 8'(n), 8'h80 + 8'(n), 8'h90 + 8'(n));
    wait_word("hold_reach_r", 32'h73727170);
    @(posedge pixel_clk);
    #1 bus.out_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      bus.in_valid = 1'b1;
      bus.in_de    = 1'b1;
      bus.in_vsync = 1'b0;
      bus.in_r     = 12'($urandom);
      bus.in_g     = 12'($urandom);
      bus.in_b     = 12'($urandom);
      @(negedge pixel_clk);
      chk("hold_word", {bus.out_k, bus.out_sym}, 36'h0_83828180);
      chk("hold_valid", 36'(bus.out_valid), 36'd1);
      if (c == 8) begin
        chk("full_level", 36'(fifo_level), 36'd8);
        chk("full_in_ready", 36'(bus.in_ready), 36'd0);
      end
      if (c == 9) chk("ovf_set", 36'(ovf_sticky), 36'd1);
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    send(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    drain(60);
    build_model();
    check_stream("hold_stream");
    chk("ovf_stays", 36'(ovf_sticky), 36'd1);

    // Random lines, blanking and sink backpressure
    got.delete();
    pq.delete();
    rnd_rdy = 1'b1;
    for (int ln = 0; ln < 20; ln++) begin
      repeat ($urandom_range(1, 3))
        send(1'b0, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
      repeat ($urandom_range(0, 2)) step();
      repeat ($urandom_range(1, 11)) begin
        send(1'b1, 1'($urandom), 8'($urandom), 8'($urandom), 8'($urandom));
        if ($urandom_range(0, 3) == 0) step();
      end
    end
    send(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    drain(400);
    rnd_rdy       = 1'b0;
    bus.out_ready = 1'b1;
    drain(20);
    build_model();
    check_stream("rand_stream");

    // Reset in the middle of a group
    got.delete();
    send(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    for (int n = 0; n < 4; n++) send(1'b1, 1'b0, 8'hA0 + 8'(n), 8'hB0 + 8'(n), 8'hC0 + 8'(n));
    wait_word("mid_reach_r", 32'hA3A2A1A0);
    @(posedge pixel_clk);
    #1 bus.out_ready = 1'b0;
    send(1'b1, 1'b0, 8'h11, 8'h22, 8'h33);
    send(1'b1, 1'b0, 8'h44, 8'h55, 8'h66);
    rst_n = 1'b0;
    @(negedge pixel_clk);
    chk("arst_level", 36'(fifo_level), 36'd0);
    @(posedge pixel_clk);
    #1 rst_n = 1'b1;
    @(negedge pixel_clk);
    chk("post_rst_level", 36'(fifo_level), 36'd0);
    chk("post_rst_word", {bus.out_k, bus.out_sym}, 36'h0);
    chk("post_rst_valid", 36'(bus.out_valid), 36'd1);
    chk("post_rst_ovf", 36'(ovf_sticky), 36'd0);
    got.delete();
    pq.delete();
    step();
    bus.out_ready = 1'b1;
    send(1'b1, 1'b0, 8'h0C, 8'h0D, 8'h0E);
    send(1'b0, 1'b0, 8'h00, 8'h00, 8'h00);
    drain(30);
    exp_q = {W_BE, 36'h0_0000000C, 36'h0_0000000D, 36'h0_0000000E, W_BS, 36'h0_01010101};
    check_stream("post_rst_line");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
